// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI frame receiver.
package spi_frame_pkg;

  // Receiver control states
  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_t;

  // Flops in each pin synchronizer before the signal is used
  localparam int SYNC_DEPTH = 2;

  // Bit counter must hold 0 .. FRAME_BITS+1 (FRAME_BITS+1 marks an oversize frame)
  function automatic int cnt_width(input int frame_bytes);
    return $clog2(8 * frame_bytes + 2);
  endfunction

endpackage

// File: rtl/spi_frame_rx_if.sv
// Parallel frame handshake between the receiver and the job-loading logic.
interface spi_frame_rx_if #(
  parameter int FRAME_BYTES = 4
);
  logic [8*FRAME_BYTES-1:0] frame_data;
  logic                     frame_valid;
  logic                     frame_ready;

  modport master (output frame_data, output frame_valid, input frame_ready);
  modport slave  (input frame_data, input frame_valid, output frame_ready);
endinterface

// File: rtl/spi_frame_rx_sync_edge.sv
// Pin synchronizer with one extra flop so rising/falling edges can be seen.
module sync_edge
  import spi_frame_pkg::*;
(
  input  logic clk_in,
  input  logic reset_in,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // [0] first capture flop, [SYNC_DEPTH-1] usable level, [SYNC_DEPTH] previous level.
  // Resets low so a chip select already held low at reset release is not seen as a fall.
  logic [SYNC_DEPTH:0] sync_r;

  // Shift the pin through the synchronizer chain
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      sync_r <= {(SYNC_DEPTH + 1){1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_DEPTH-1:0], din};
    end
  end

  assign level = sync_r[SYNC_DEPTH-1];
  assign rise  = sync_r[SYNC_DEPTH-1] & ~sync_r[SYNC_DEPTH];
  assign fall  = ~sync_r[SYNC_DEPTH-1] & sync_r[SYNC_DEPTH];

endmodule

// File: rtl/spi_frame_rx.sv
// Chip-select-delimited SPI (mode 0) frame receiver with valid/ready output.
module spi_frame_rx
  import spi_frame_pkg::*;
#(
  parameter int FRAME_BYTES = 4
) (
  input  logic           clk_in,
  input  logic           reset_in,
  input  logic           sck_in,
  input  logic           sdi_in,
  input  logic           cs_n_in,
  spi_frame_rx_if.master frm,
  output logic           busy,
  output logic           err_len,
  output logic           err_overrun,
  output logic [7:0]     err_count
);

  localparam int FRAME_BITS = 8 * FRAME_BYTES;
  localparam int CNT_W      = cnt_width(FRAME_BYTES);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic sck_level_s, sck_rise_s, sck_fall_s;
  logic cs_level_s, cs_rise_s, cs_fall_s;
  logic unused_s;
  logic [SYNC_DEPTH-1:0] sdi_sync_r;

  state_t                state_r, state_nxt_s;
  logic [FRAME_BITS-1:0] shift_r, shift_nxt_s;
  logic [CNT_W-1:0]      bit_cnt_r, cnt_nxt_s;
  logic [FRAME_BITS-1:0] frame_data_r;
  logic                  frame_valid_r;
  logic                  err_len_r, err_overrun_r;
  logic [7:0]            err_count_r;
  logic close_s, consume_s, good_s, load_s, ovr_s, len_s;

  sync_edge u_sck_sync (
    .clk_in(clk_in), .reset_in(reset_in), .din(sck_in),
    .level(sck_level_s), .rise(sck_rise_s), .fall(sck_fall_s)
  );

  sync_edge u_cs_sync (
    .clk_in(clk_in), .reset_in(reset_in), .din(cs_n_in),
    .level(cs_level_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  // Only the sck rising edge matters in mode 0
  assign unused_s = sck_level_s ^ sck_fall_s;

  // Data pin synchronizer, same depth as the sck level used for edge detect
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      sdi_sync_r <= {SYNC_DEPTH{1'b0}};
    end else begin
      sdi_sync_r <= {sdi_sync_r[SYNC_DEPTH-2:0], sdi_in};
    end
  end

  // Next state, shift/count update and frame-close decisions
  always_comb begin
    state_nxt_s = state_r;
    shift_nxt_s = shift_r;
    cnt_nxt_s   = bit_cnt_r;
    close_s     = 1'b0;
    case (state_r)
      WAIT_IDLE: begin
        if (cs_level_s) state_nxt_s = IDLE;
        else            state_nxt_s = WAIT_IDLE;
      end
      IDLE: begin
        shift_nxt_s = {FRAME_BITS{1'b0}};
        cnt_nxt_s   = {CNT_W{1'b0}};
        if (cs_fall_s) state_nxt_s = SHIFT;
        else           state_nxt_s = IDLE;
      end
      SHIFT: begin
        if (sck_rise_s) begin
          if (bit_cnt_r < CNT_FULL) shift_nxt_s = {shift_r[FRAME_BITS-2:0], sdi_sync_r[SYNC_DEPTH-1]};
          else                      shift_nxt_s = shift_r;
          if (bit_cnt_r < CNT_SAT)  cnt_nxt_s = bit_cnt_r + CNT_W'(1);
          else                      cnt_nxt_s = bit_cnt_r;
        end else begin
          shift_nxt_s = shift_r;
          cnt_nxt_s   = bit_cnt_r;
        end
        // Close uses the count including a bit shifted in this same cycle
        if (cs_rise_s) begin
          state_nxt_s = IDLE;
          close_s     = 1'b1;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      default: state_nxt_s = WAIT_IDLE;
    endcase
    consume_s = frame_valid_r & frm.frame_ready;
    good_s    = close_s & (cnt_nxt_s == CNT_FULL);
    load_s    = good_s & (~frame_valid_r | consume_s);
    ovr_s     = good_s & frame_valid_r & ~consume_s;
    len_s     = close_s & (cnt_nxt_s != {CNT_W{1'b0}}) & (cnt_nxt_s != CNT_FULL);
  end

  // State, shift register, output frame and error registers
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_r       <= WAIT_IDLE;
      shift_r       <= {FRAME_BITS{1'b0}};
      bit_cnt_r     <= {CNT_W{1'b0}};
      frame_data_r  <= {FRAME_BITS{1'b0}};
      frame_valid_r <= 1'b0;
      err_len_r     <= 1'b0;
      err_overrun_r <= 1'b0;
      err_count_r   <= 8'd0;
    end else begin
      state_r   <= state_nxt_s;
      shift_r   <= shift_nxt_s;
      bit_cnt_r <= cnt_nxt_s;
      if (load_s) begin
        frame_data_r  <= shift_nxt_s;
        frame_valid_r <= 1'b1;
      end else if (consume_s) begin
        frame_valid_r <= 1'b0;
      end
      err_len_r     <= len_s;
      err_overrun_r <= ovr_s;
      if ((len_s | ovr_s) && (err_count_r != 8'd255)) begin
        err_count_r <= err_count_r + 8'd1;
      end
    end
  end

  assign frm.frame_data  = frame_data_r;
  assign frm.frame_valid = frame_valid_r;
  assign busy            = (state_r == SHIFT);
  assign err_len         = err_len_r;
  assign err_overrun     = err_overrun_r;
  assign err_count       = err_count_r;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Self-checking bench for spi_frame_rx: directed scenarios plus random frames
// checked against a frame-level reference model.
module tb_spi_frame_rx;

  localparam int FRAME_BITS = 32;

  logic clk_in = 1'b0;
  logic reset_in, sck_in, sdi_in, cs_n_in;
  logic busy, err_len, err_overrun;
  logic [7:0] err_count;

  spi_frame_rx_if #(.FRAME_BYTES(4)) fif ();

  spi_frame_rx #(.FRAME_BYTES(4)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .sck_in(sck_in), .sdi_in(sdi_in),
    .cs_n_in(cs_n_in), .frm(fif), .busy(busy), .err_len(err_len),
    .err_overrun(err_overrun), .err_count(err_count)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;
  int len_seen = 0;
  int ovr_seen = 0;

  // Reference model state
  bit          m_valid;
  logic [31:0] m_data;
  int          m_errcnt;
  int          m_len;
  int          m_ovr;

  // Count error pulses mid-cycle
  always @(negedge clk_in) begin
    if (err_len === 1'b1) len_seen <= len_seen + 1;
    if (err_overrun === 1'b1) ovr_seen <= ovr_seen + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".valid"}, 64'(fif.frame_valid), 64'(m_valid));
    check({tag, ".data"}, 64'(fif.frame_data), 64'(m_data));
    check({tag, ".err_count"}, 64'(err_count), 64'(m_errcnt));
    check({tag, ".len_pulses"}, 64'(len_seen), 64'(m_len));
    check({tag, ".ovr_pulses"}, 64'(ovr_seen), 64'(m_ovr));
    check({tag, ".busy"}, 64'(busy), 64'd0);
  endtask

  function automatic void bump_err();
    if (m_errcnt < 255) m_errcnt++;
  endfunction

  task automatic send_bits(input logic [63:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      sdi_in = bits[n-1-i];
      repeat (2) @(negedge clk_in);
      sck_in = 1'b1;
      repeat (2) @(negedge clk_in);
      sck_in = 1'b0;
    end
  endtask

  // One complete frame; optionally pulses frame_ready on exactly the close edge.
  // v_pre / v_post: frame_valid after the 2nd and 3rd clk edge following cs rise.
  task automatic send_frame(input logic [63:0] bits, input int n, input bit ready_at_close,
                            output logic v_pre, output logic v_post);
    bit consumed;
    @(negedge clk_in);
    cs_n_in = 1'b0;
    repeat (3) @(negedge clk_in);
    send_bits(bits, n);
    repeat (2) @(negedge clk_in);
    cs_n_in = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    v_pre = fif.frame_valid;
    if (ready_at_close) fif.frame_ready = 1'b1;
    @(negedge clk_in);
    v_post = fif.frame_valid;
    fif.frame_ready = 1'b0;
    // Frame-level expectation
    consumed = ready_at_close && m_valid;
    if (n == 0) begin
      if (consumed) m_valid = 1'b0;
    end else if (n == FRAME_BITS) begin
      if (!m_valid || consumed) begin
        m_data  = bits[31:0];
        m_valid = 1'b1;
      end else begin
        m_ovr++;
        bump_err();
      end
    end else begin
      m_len++;
      bump_err();
      if (consumed) m_valid = 1'b0;
    end
    repeat (3) @(negedge clk_in);
  endtask

  task automatic consume();
    @(negedge clk_in);
    fif.frame_ready = 1'b1;
    @(negedge clk_in);
    fif.frame_ready = 1'b0;
    m_valid = 1'b0;
  endtask

  initial begin
    logic vp, vq;
    logic [63:0] rbits;
    int rlen;

    reset_in = 1'b1; sck_in = 1'b0; sdi_in = 1'b0; cs_n_in = 1'b1;
    fif.frame_ready = 1'b0;
    m_valid = 1'b0; m_data = 32'd0; m_errcnt = 0; m_len = 0; m_ovr = 0;
    repeat (3) @(negedge clk_in);
    check_state("reset");
    reset_in = 1'b0;
    repeat (4) @(negedge clk_in);

    // Good frame with latency check
    send_frame(64'hDEADBEEF, 32, 1'b0, vp, vq);
    check("good.latency_pre", 64'(vp), 64'd0);
    check("good.latency_post", 64'(vq), 64'd1);
    check_state("good");

    // Overrun: old frame kept
    send_frame(64'h12345678, 32, 1'b0, vp, vq);
    check_state("overrun");
    consume();
    check("overrun.consume_drop", 64'(fif.frame_valid), 64'd0);
    check_state("after_consume");

    // Length errors and empty CS toggle
    send_frame(64'h7FFFFFFF, 31, 1'b0, vp, vq);
    check_state("len31");
    send_frame(64'hAB_CDEF0123, 40, 1'b0, vp, vq);
    check_state("len40");
    send_frame(64'h0, 0, 1'b0, vp, vq);
    check_state("cs_only");

    // Simultaneous close and consume
    send_frame(64'hCAFEF00D, 32, 1'b0, vp, vq);
    check_state("pre_simul");
    send_frame(64'hA5A5A5A5, 32, 1'b1, vp, vq);
    check("simul.valid_at_close", 64'(vq), 64'd1);
    check_state("simul");
    consume();

    // Reset in the middle of a frame, then a frame that started before release
    @(negedge clk_in);
    cs_n_in = 1'b0;
    repeat (3) @(negedge clk_in);
    send_bits(64'hFFF, 12);
    check("midreset.busy", 64'(busy), 64'd1);
    reset_in = 1'b1;
    repeat (2) @(negedge clk_in);
    reset_in = 1'b0;
    m_valid = 1'b0; m_data = 32'd0; m_errcnt = 0;
    send_bits(64'hABCDE, 20);
    repeat (2) @(negedge clk_in);
    cs_n_in = 1'b1;
    repeat (6) @(negedge clk_in);
    check_state("midreset");
    send_frame(64'h0BADF00D, 32, 1'b0, vp, vq);
    check_state("after_reset_frame");

    // Random frames against the model
    for (int k = 0; k < 12; k++) begin
      rbits = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0, 1:    rlen = 32;
        2:       rlen = $urandom_range(1, 40);
        default: rlen = 0;
      endcase
      if ($urandom_range(0, 1) == 1) consume();
      send_frame(rbits, rlen, 1'b0, vp, vq);
      check_state($sformatf("rand%0d", k));
    end

    // Saturating error counter
    for (int k = 0; k < 300; k++) send_frame(64'h1, 1, 1'b0, vp, vq);
    check_state("saturate");
    check("saturate.value", 64'(err_count), 64'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound on run time
  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
